// File: rtl/bus_responder_pkg.sv
// Shared types for the ibus/dbus responder: request/response structs, FSM
// encoding, LFSR seed and the byte-strobe merge helper.
package bus_responder_pkg;

  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef logic [15:0] u16;
  typedef logic [7:0]  u8;

  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;

  typedef struct packed {
    logic       valid;
    u64         addr;
    logic [2:0] size;
    u8          strobe;
    u64         data;
  } dbus_req_t;

  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u64   data;
  } dbus_resp_t;

  typedef enum logic [1:0] {RSP_IDLE, RSP_WAIT, RSP_RESP} bus_rsp_state_t;

  localparam u16 RSP_LFSR_SEED = 16'hACE1;

  // Byte i of the result comes from nw when strobe[i] is set, else from old.
  function automatic u64 strobe_merge(u64 old, u64 nw, u8 strobe);
    u64 mask;
    for (int i = 0; i < 8; i++) mask[i*8 +: 8] = {8{strobe[i]}};
    return (old & ~mask) | (nw & mask);
  endfunction

endpackage

// File: rtl/bus_resp_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), advances every cycle; used to
// randomise response latency when BUS_RESPONDER_RANDOM_STALL_EN is defined.
module bus_resp_lfsr
  import bus_responder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  output u16   value
);

  logic feedback;

  assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) value <= RSP_LFSR_SEED;
    else      value <= {value[14:0], feedback};
  end

endmodule

// File: rtl/bus_responder.sv
// Responder for the core's ibus/dbus: one 64-bit word memory, dbus-over-ibus
// priority, one transaction in flight. Optional macro: BUS_RESPONDER_RANDOM_STALL_EN.
//
// Handshake: addr_ok is combinational and only asserts in IDLE for the granted
// port; once addr_ok is seen the request is latched and the requester may drop
// valid or change fields. data_ok pulses for one cycle, LATENCY cycles later.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2,
  parameter u64 BASE_ADDR = 64'h8000_0000
) (
  input  logic           clk,
  input  logic           rst,
  input  ibus_req_t      ireq,
  output ibus_resp_t     iresp,
  input  dbus_req_t      dreq,
  output dbus_resp_t     dresp,
  output bus_rsp_state_t dbg_state
);

  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = 8;

  bus_rsp_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_load;
  logic [IDX_W-1:0] lat_idx;
  u64               lat_data;
  u8                lat_strobe;
  logic             lat_dport;
  logic             lat_hi;

  u64               d_off;
  u64               i_off;
  logic [IDX_W-1:0] d_idx;
  logic [IDX_W-1:0] i_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             d_grant;
  logic             i_grant;
  logic             mem_we;
  logic             rsp_d;
  logic             rsp_i;

  u64 mem [MEM_WORDS];
  u64 rd_word;

  // Offsets wrap modulo 2^64 and only the word-index bits are kept, so any
  // out-of-range address aliases silently into the array.
  assign d_off = dreq.addr - BASE_ADDR;
  assign i_off = ireq.addr - BASE_ADDR;
  assign d_idx = d_off[IDX_W+2:3];
  assign i_idx = i_off[IDX_W+2:3];

  assign d_grant = rst && (state == RSP_IDLE) && dreq.valid;
  assign i_grant = rst && (state == RSP_IDLE) && !dreq.valid && ireq.valid;

`ifdef BUS_RESPONDER_RANDOM_STALL_EN
  u16 lfsr;

  bus_resp_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  assign cnt_load = CNT_W'(LATENCY - 1) + CNT_W'(lfsr[1:0]);
`else
  assign cnt_load = CNT_W'(LATENCY - 1);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RSP_IDLE;
      cnt        <= '0;
      lat_idx    <= '0;
      lat_data   <= '0;
      lat_strobe <= '0;
      lat_dport  <= 1'b0;
      lat_hi     <= 1'b0;
    end else begin
      case (state)
        RSP_IDLE: begin
          if (d_grant || i_grant) begin
            lat_dport  <= d_grant;
            lat_idx    <= d_grant ? d_idx : i_idx;
            lat_data   <= d_grant ? dreq.data : '0;
            lat_strobe <= d_grant ? dreq.strobe : '0;
            lat_hi     <= i_off[2];
            cnt        <= cnt_load;
            state      <= (cnt_load == '0) ? RSP_RESP : RSP_WAIT;
          end
        end
        RSP_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt <= CNT_W'(1)) state <= RSP_RESP;
        end
        RSP_RESP: begin
          lat_strobe <= '0;
          state      <= RSP_IDLE;
        end
        default: state <= RSP_IDLE;
      endcase
    end
  end

  // Single-port RAM: reads every cycle except RESP, where a dbus write merges
  // into the word read on the previous cycle.
  assign rd_idx = (state == RSP_IDLE) ? (d_grant ? d_idx : i_idx) : lat_idx;
  assign mem_we = rst && (state == RSP_RESP) && lat_dport && (lat_strobe != '0);

  always_ff @(posedge clk) begin
    if (mem_we) mem[lat_idx] <= strobe_merge(rd_word, lat_data, lat_strobe);
    else        rd_word      <= mem[rd_idx];
  end

  assign rsp_d = (state == RSP_RESP) && lat_dport;
  assign rsp_i = (state == RSP_RESP) && !lat_dport;

  assign dresp.addr_ok = d_grant;
  assign dresp.data_ok = rsp_d;
  assign dresp.data    = rsp_d ? rd_word : '0;

  assign iresp.addr_ok = i_grant;
  assign iresp.data_ok = rsp_i;
  assign iresp.data    = rsp_i ? (lat_hi ? rd_word[63:32] : rd_word[31:0]) : '0;

  assign dbg_state = state;

  logic unused_bits;
  assign unused_bits = ^{dreq.size, d_off[63:IDX_W+3], d_off[2:0],
                         i_off[63:IDX_W+3], i_off[1:0]
`ifdef BUS_RESPONDER_RANDOM_STALL_EN
                         , lfsr[15:2]
`endif
                        };

endmodule

// File: tb/tb_bus_responder.sv
// Directed bench for bus_responder: write/read, strobes, ibus half select,
// arbitration, reset mid-write, address wrap and a randomised dbus sequence.
module tb_bus_responder;
  import bus_responder_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  ibus_req_t      ireq;
  ibus_resp_t     iresp;
  dbus_req_t      dreq;
  dbus_resp_t     dresp;
  bus_rsp_state_t dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  u64 model [int];
  logic [63:0] exp_q [$];

  bus_responder dut (
    .clk       (clk),
    .rst       (rst),
    .ireq      (ireq),
    .iresp     (iresp),
    .dreq      (dreq),
    .dresp     (dresp),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input u64 obs, input u64 exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic u64 ref_merge(u64 old, u64 nw, u8 strobe);
    u64 r;
    r = old;
    for (int i = 0; i < 8; i++) if (strobe[i]) r[i*8 +: 8] = nw[i*8 +: 8];
    return r;
  endfunction

  // Issues one dbus request, drops valid and scrambles fields after addr_ok,
  // then waits (bounded) for data_ok and checks its latency and pulse width.
  task automatic d_txn(input u64 addr, input u64 data, input u8 strobe, output u64 rdata);
    int lat;
    bit seen;
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = addr; dreq.data = data;
    dreq.strobe = strobe; dreq.size = 3'd3;
    #1;
    check("d_addr_ok", u64'(dresp.addr_ok), 64'd1);
    check("d_i_addr_ok_quiet", u64'(iresp.addr_ok), 64'd0);
    @(posedge clk); #1;
    dreq.valid = 1'b0; dreq.addr = ~addr; dreq.data = ~data; dreq.strobe = ~strobe;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (dresp.data_ok) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("d_data_ok_seen", u64'(seen), 64'd1);
`ifdef BUS_RESPONDER_RANDOM_STALL_EN
    check("d_latency_range", u64'(lat >= 2 && lat <= 5), 64'd1);
`else
    check("d_latency", u64'(lat), 64'd2);
`endif
    rdata = dresp.data;
    @(posedge clk); #1;
    check("d_data_ok_pulse", u64'(dresp.data_ok), 64'd0);
  endtask

  task automatic i_txn(input u64 addr, output u32 rdata);
    int lat;
    bit seen;
    @(posedge clk); #1;
    ireq.valid = 1'b1; ireq.addr = addr;
    #1;
    check("i_addr_ok", u64'(iresp.addr_ok), 64'd1);
    @(posedge clk); #1;
    ireq.valid = 1'b0; ireq.addr = ~addr;
    lat = 1;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (iresp.data_ok) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("i_data_ok_seen", u64'(seen), 64'd1);
`ifndef BUS_RESPONDER_RANDOM_STALL_EN
    check("i_latency", u64'(lat), 64'd2);
`endif
    check("i_d_data_ok_quiet", u64'(dresp.data_ok), 64'd0);
    rdata = iresp.data;
    @(posedge clk); #1;
    check("i_data_ok_pulse", u64'(iresp.data_ok), 64'd0);
  endtask

  initial begin
    u64 rd;
    u32 ird;
    int idx;
    u64 addr;
    u64 wdata;
    u8  strb;

    rst  = 1'b0;
    ireq = '0;
    dreq = '0;

    // Reset state, with both requests valid to show addr_ok is held low.
    repeat (2) @(posedge clk);
    #1;
    ireq.valid = 1'b1; dreq.valid = 1'b1;
    #1;
    check("rst_d_flags", u64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("rst_d_data", dresp.data, 64'd0);
    check("rst_i_flags", u64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
    check("rst_i_data", u64'(iresp.data), 64'd0);
    check("rst_state", u64'(dbg_state), u64'(RSP_IDLE));
    ireq.valid = 1'b0; dreq.valid = 1'b0;
    @(negedge clk) rst = 1'b1;

    // Full write then read.
    d_txn(64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, rd);
    d_txn(64'h8000_0010, 64'h0, 8'h00, rd);
    check("full_write_read", rd, 64'h1122_3344_5566_7788);

    // Partial write.
    d_txn(64'h8000_0010, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, rd);
    d_txn(64'h8000_0010, 64'h0, 8'h00, rd);
    check("partial_write_read", rd, 64'h1122_3344_BBBB_BBBB);

    // ibus half-word select.
    i_txn(64'h8000_0014, ird);
    check("ibus_hi_half", u64'(ird), 64'h1122_3344);
    i_txn(64'h8000_0010, ird);
    check("ibus_lo_half", u64'(ird), 64'hBBBB_BBBB);

`ifndef BUS_RESPONDER_RANDOM_STALL_EN
    // Simultaneous requests: dbus first, ibus granted after dbus data_ok.
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010; dreq.strobe = 8'h00;
    ireq.valid = 1'b1; ireq.addr = 64'h8000_0010;
    #1;
    check("sim_c0_d_addr_ok", u64'(dresp.addr_ok), 64'd1);
    check("sim_c0_i_addr_ok", u64'(iresp.addr_ok), 64'd0);
    @(posedge clk); #1;
    dreq.valid = 1'b0;
    check("sim_c1_oks", u64'({dresp.addr_ok, dresp.data_ok, iresp.addr_ok, iresp.data_ok}), 64'd0);
    @(posedge clk); #1;
    check("sim_c2_d_data_ok", u64'(dresp.data_ok), 64'd1);
    check("sim_c2_d_data", dresp.data, 64'h1122_3344_BBBB_BBBB);
    check("sim_c2_i_oks", u64'({iresp.addr_ok, iresp.data_ok}), 64'd0);
    @(posedge clk); #1;
    check("sim_c3_i_addr_ok", u64'(iresp.addr_ok), 64'd1);
    check("sim_c3_d_oks", u64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    @(posedge clk); #1;
    ireq.valid = 1'b0;
    check("sim_c4_i_data_ok", u64'(iresp.data_ok), 64'd0);
    @(posedge clk); #1;
    check("sim_c5_i_data_ok", u64'(iresp.data_ok), 64'd1);
    check("sim_c5_i_data", u64'(iresp.data), 64'hBBBB_BBBB);
    check("sim_c5_state", u64'(dbg_state), u64'(RSP_RESP));
`endif

    // Reset during the WAIT of a write: write must be dropped.
    @(posedge clk); #1;
    dreq.valid = 1'b1; dreq.addr = 64'h8000_0010;
    dreq.data = 64'hFFFF_FFFF_FFFF_FFFF; dreq.strobe = 8'hFF;
    #1;
    check("rstw_addr_ok", u64'(dresp.addr_ok), 64'd1);
    @(posedge clk); #1;
    check("rstw_state_wait", u64'(dbg_state), u64'(RSP_WAIT));
    rst = 1'b0;
    #1;
    check("rstw_d_flags", u64'({dresp.addr_ok, dresp.data_ok}), 64'd0);
    check("rstw_d_data", dresp.data, 64'd0);
    check("rstw_i_all", u64'({iresp.addr_ok, iresp.data_ok, iresp.data}), 64'd0);
    check("rstw_state", u64'(dbg_state), u64'(RSP_IDLE));
    dreq.valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    d_txn(64'h8000_0010, 64'h0, 8'h00, rd);
    check("rstw_write_dropped", rd, 64'h1122_3344_BBBB_BBBB);

    // Wrap: one window above aliases word 0, one word below base aliases the top.
    d_txn(64'h8000_8000, 64'hDEAD_BEEF_0000_0001, 8'hFF, rd);
    d_txn(64'h8000_0000, 64'h0, 8'h00, rd);
    check("wrap_above", rd, 64'hDEAD_BEEF_0000_0001);
    d_txn(64'h7FFF_FFF8, 64'h5A5A_A5A5_0F0F_F0F0, 8'hFF, rd);
    d_txn(64'h8000_7FF8, 64'h0, 8'h00, rd);
    check("wrap_below", rd, 64'h5A5A_A5A5_0F0F_F0F0);
    model[0]    = 64'hDEAD_BEEF_0000_0001;
    model[2]    = 64'h1122_3344_BBBB_BBBB;
    model[4095] = 64'h5A5A_A5A5_0F0F_F0F0;

    // Random dbus traffic around the wrap point, alternating aliased addresses.
    for (int n = 0; n < 200; n++) begin
      idx  = ($urandom_range(0, 7) + 4092) % 4096;
      addr = 64'h8000_0000 + u64'(idx) * 8 + ($urandom_range(0, 1) ? 64'h8000 : 64'h0);
      if (model.exists(idx) && $urandom_range(0, 1)) begin
        exp_q.push_back(model[idx]);
        d_txn(addr, {$urandom, $urandom}, 8'h00, rd);
        check("rand_read", rd, exp_q.pop_front());
      end else begin
        wdata = {$urandom, $urandom};
        strb  = model.exists(idx) ? u8'($urandom_range(1, 255)) : 8'hFF;
        model[idx] = model.exists(idx) ? ref_merge(model[idx], wdata, strb) : wdata;
        d_txn(addr, wdata, strb, rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
